// File: rtl/cubic_pkg.sv
// Shared constants and width helpers for the Catmull-Rom cubic interpolator.
package cubic_pkg;

    // Per-weight polynomial coefficients, in this order: T^3, T^2*2^F, T*2^(2F), 2^(3F)
    localparam int CR_C3 [4] = '{-1,  3, -3,  1};
    localparam int CR_C2 [4] = '{ 2, -5,  4, -1};
    localparam int CR_C1 [4] = '{-1,  0,  1,  0};
    localparam int CR_C0 [4] = '{ 0,  2,  0,  0};

    function automatic int weight_w(input int frac_w);
        return 3 * frac_w + 3;
    endfunction

    function automatic int sum_w(input int frac_w, input int pix_w);
        return 3 * frac_w + pix_w + 6;
    endfunction

endpackage

// File: rtl/cubic_weight_gen.sv
// Stages S1-S2: fractional position T -> signed Catmull-Rom weights W0..W3.
module cubic_weight_gen
    import cubic_pkg::*;
#(
    parameter int FRAC_W = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en_i,
    input  logic                            valid_i,
    input  logic [FRAC_W-1:0]               t_i,
    output logic                            valid_o,
    output logic [4*weight_w(FRAC_W)-1:0]   w_o
);
    localparam int WW = weight_w(FRAC_W);
    localparam int F2 = 2 * FRAC_W;
    localparam int F3 = 3 * FRAC_W;
    localparam logic signed [WW-1:0] ONE_3F = WW'(1) << F3;

    logic                 v1_q, v2_q;
    logic [FRAC_W-1:0]    t1_q;
    logic [F2-1:0]        t2_d, t2_q;
    logic [F3-1:0]        t3;
    logic signed [WW-1:0] t3_s, t2_s, t1_s;
    logic signed [WW-1:0] w_d [4];
    logic signed [WW-1:0] w_q [4];

    always_comb begin
        t2_d = F2'(t_i) * F2'(t_i);
        t3   = F3'(t2_q) * F3'(t1_q);
        t3_s = WW'(t3);
        t2_s = WW'({t2_q, {FRAC_W{1'b0}}});
        t1_s = WW'({t1_q, {F2{1'b0}}});
        for (int i = 0; i < 4; i++) begin
            w_d[i] = WW'(CR_C3[i]) * t3_s + WW'(CR_C2[i]) * t2_s
                   + WW'(CR_C1[i]) * t1_s + WW'(CR_C0[i]) * ONE_3F;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            t1_q <= '0;
            t2_q <= '0;
            for (int i = 0; i < 4; i++) w_q[i] <= '0;
        end else if (en_i) begin
            v1_q <= valid_i;
            t1_q <= t_i;
            t2_q <= t2_d;
            v2_q <= v1_q;
            for (int i = 0; i < 4; i++) w_q[i] <= w_d[i];
        end
    end

    always_comb begin
        w_o = '0;
        for (int i = 0; i < 4; i++) w_o[i*WW +: WW] = w_q[i];
    end

    assign valid_o = v2_q;

endmodule

// File: rtl/cubic_interp_pipe.sv
// Streaming 1-D Catmull-Rom interpolator, 4-cycle latency, one beat per cycle.
// Define CUBIC_CLAMP_EN to saturate the result; otherwise it wraps to PIX_W bits.
module cubic_interp_pipe
    import cubic_pkg::*;
#(
    parameter int PIX_W  = 8,
    parameter int FRAC_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [FRAC_W-1:0]   in_frac,
    input  logic [4*PIX_W-1:0]  in_pix,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PIX_W-1:0]    out_pix
);
    localparam int WW = weight_w(FRAC_W);
    localparam int SW = sum_w(FRAC_W, PIX_W);
    localparam int PW = WW + PIX_W + 1;
    localparam int SH = 3 * FRAC_W + 1;
    localparam int RW = SW - SH;
    localparam logic signed [SW-1:0] RND = SW'(1) << (3 * FRAC_W);

    logic                 en;
    logic                 v2, v3_q, v4_q, out_valid_q;
    logic [4*PIX_W-1:0]   pix1_q, pix2_q;
    logic [4*WW-1:0]      w_flat;
    logic signed [WW-1:0] w [4];
    logic signed [PW-1:0] prod_d [4];
    logic signed [PW-1:0] prod_q [4];
    logic signed [SW-1:0] sum_d, sum_q;
    logic [PIX_W-1:0]     out_pix_d, out_pix_q;

    // A single enable freezes the whole pipe while the output is stalled.
    assign en        = !out_valid_q || out_ready;
    assign in_ready  = en;
    assign out_valid = out_valid_q;
    assign out_pix   = out_pix_q;

    cubic_weight_gen #(.FRAC_W(FRAC_W)) u_wgen (
        .clk     (clk),
        .rst     (rst),
        .en_i    (en),
        .valid_i (in_valid),
        .t_i     (in_frac),
        .valid_o (v2),
        .w_o     (w_flat)
    );

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w[i]      = w_flat[i*WW +: WW];
            prod_d[i] = PW'(w[i]) * PW'($signed({1'b0, pix2_q[i*PIX_W +: PIX_W]}));
        end
        sum_d = SW'(prod_q[0]) + SW'(prod_q[1]) + SW'(prod_q[2]) + SW'(prod_q[3]);
    end

`ifdef CUBIC_CLAMP_EN
    localparam logic signed [RW-1:0] RMAX = RW'((1 << PIX_W) - 1);
    logic signed [RW-1:0] r;

    always_comb begin
        r = RW'((sum_q + RND) >>> SH);
        if (r[RW-1])
            out_pix_d = '0;
        else if (r > RMAX)
            out_pix_d = '1;
        else
            out_pix_d = r[PIX_W-1:0];
    end
`else
    always_comb out_pix_d = PIX_W'((sum_q + RND) >>> SH);
`endif

    // The sum is registered ahead of round/clamp so S4 carries only the adder tree.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix1_q      <= '0;
            pix2_q      <= '0;
            v3_q        <= 1'b0;
            v4_q        <= 1'b0;
            sum_q       <= '0;
            out_valid_q <= 1'b0;
            out_pix_q   <= '0;
            for (int i = 0; i < 4; i++) prod_q[i] <= '0;
        end else if (en) begin
            pix1_q      <= in_pix;
            pix2_q      <= pix1_q;
            v3_q        <= v2;
            for (int i = 0; i < 4; i++) prod_q[i] <= prod_d[i];
            v4_q        <= v3_q;
            sum_q       <= sum_d;
            out_valid_q <= v4_q;
            if (v4_q) out_pix_q <= out_pix_d;
        end
    end

endmodule

// File: tb/tb_cubic_interp_pipe.sv
// Bench for cubic_interp_pipe: 8/8 instance for directed, random and reset cases,
// 10/12 instance for a full-T sweep; outputs checked against an integer model.
module tb_cubic_interp_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [7:0]  a_in_frac;
    logic [31:0] a_in_pix;
    logic [7:0]  a_out_pix;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [11:0] b_in_frac;
    logic [39:0] b_in_pix;
    logic [9:0]  b_out_pix;

    cubic_interp_pipe #(.PIX_W(8), .FRAC_W(8)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_frac(a_in_frac), .in_pix(a_in_pix),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_pix(a_out_pix)
    );

    cubic_interp_pipe #(.PIX_W(10), .FRAC_W(12)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_frac(b_in_frac), .in_pix(b_in_pix),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_pix(b_out_pix)
    );

    int     n_vec = 0;
    int     n_err = 0;
    longint a_exp[$];
    longint b_exp[$];
    bit     a_rand_rdy = 1'b0;
    bit     b_rand_rdy = 1'b0;

    // Weighted sum straight from the closed-form integer weights.
    function automatic longint model(input int f, input int pw, input longint t,
                                     input longint p0, input longint p1,
                                     input longint p2, input longint p3);
        longint one = 1;
        longint a  = one << f;
        longint b  = one << (2 * f);
        longint c  = one << (3 * f);
        longint t2 = t * t;
        longint t3 = t2 * t;
        longint w0 = -t3 + 2 * t2 * a - t * b;
        longint w1 = 3 * t3 - 5 * t2 * a + 2 * c;
        longint w2 = -3 * t3 + 4 * t2 * a + t * b;
        longint w3 = t3 - t2 * a;
        longint s  = w0 * p0 + w1 * p1 + w2 * p2 + w3 * p3;
        longint r  = (s + c) >>> (3 * f + 1);
        longint mx = (one << pw) - 1;
`ifdef CUBIC_CLAMP_EN
        if (r < 0) return 0;
        if (r > mx) return mx;
        return r;
`else
        return r & mx;
`endif
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        a_out_ready = a_rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
        b_out_ready = b_rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (a_out_valid) begin
                if (a_exp.size() == 0) check("a_spurious_out", 1, 0);
                else begin
                    check("a_out_pix", a_out_pix, a_exp[0]);
                    if (a_out_ready) void'(a_exp.pop_front());
                end
            end
            if (b_out_valid) begin
                if (b_exp.size() == 0) check("b_spurious_out", 1, 0);
                else begin
                    check("b_out_pix", b_out_pix, b_exp[0]);
                    if (b_out_ready) void'(b_exp.pop_front());
                end
            end
        end
    end

    task automatic send_a(input int t, input int p0, input int p1, input int p2, input int p3);
        int guard = 0;
        @(negedge clk);
        a_in_valid = 1'b1;
        a_in_frac  = t[7:0];
        a_in_pix   = {p3[7:0], p2[7:0], p1[7:0], p0[7:0]};
        #1;
        while (!a_in_ready) begin
            guard++;
            if (guard > 200) begin
                check("a_accept_timeout", 0, 1);
                a_in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            #1;
        end
        a_exp.push_back(model(8, 8, t, p0, p1, p2, p3));
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
    endtask

    task automatic send_b(input int t, input int p0, input int p1, input int p2, input int p3);
        int guard = 0;
        @(negedge clk);
        b_in_valid = 1'b1;
        b_in_frac  = t[11:0];
        b_in_pix   = {p3[9:0], p2[9:0], p1[9:0], p0[9:0]};
        #1;
        while (!b_in_ready) begin
            guard++;
            if (guard > 200) begin
                check("b_accept_timeout", 0, 1);
                b_in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            #1;
        end
        b_exp.push_back(model(12, 10, t, p0, p1, p2, p3));
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
    endtask

    task automatic drain(input bit which_b);
        int guard = 0;
        while (guard < 1000 && (which_b ? (b_exp.size() != 0 || b_out_valid)
                                        : (a_exp.size() != 0 || a_out_valid))) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        if (which_b) check("b_drained", b_exp.size(), 0);
        else         check("a_drained", a_exp.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int seen;
        rst = 1'b1;
        a_in_valid = 1'b0; a_in_frac = '0; a_in_pix = '0;
        b_in_valid = 1'b0; b_in_frac = '0; b_in_pix = '0;
        repeat (3) @(posedge clk);
        #1;
        check("a_rst_out_valid", a_out_valid, 0);
        check("a_rst_out_pix", a_out_pix, 0);
        check("b_rst_out_valid", b_out_valid, 0);
        check("b_rst_out_pix", b_out_pix, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("a_in_ready_after_rst", a_in_ready, 1);

        // Hand-computed values that pin the model.
        check("pin_t0", model(8, 8, 0, 3, 77, 200, 9), 77);
        check("pin_linear", model(8, 8, 64, 0, 64, 128, 192), 80);
        check("pin_half", model(8, 8, 128, 0, 100, 200, 255), 153);
`ifdef CUBIC_CLAMP_EN
        check("pin_over", model(8, 8, 128, 0, 255, 255, 0), 255);
        check("pin_under", model(8, 8, 128, 255, 0, 0, 255), 0);
`else
        check("pin_over", model(8, 8, 128, 0, 255, 255, 0), 31);
        check("pin_under", model(8, 8, 128, 255, 0, 0, 255), 224);
`endif
        check("pin_b_t0", model(12, 10, 0, 1023, 0, 1023, 0), 0);
        check("pin_b_quarter", model(12, 10, 1024, 1023, 0, 1023, 0), 160);
        check("pin_b_half", model(12, 10, 2048, 1023, 0, 1023, 0), 512);

        // Latency: accepted at edge N, visible only after edge N+4.
        send_a(0, 3, 77, 200, 9);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            check("lat_early_valid", a_out_valid, 0);
        end
        @(negedge clk);
        #1;
        check("lat_valid", a_out_valid, 1);
        check("lat_pix", a_out_pix, 77);
        drain(1'b0);

        send_a(64, 0, 64, 128, 192);
        send_a(128, 0, 100, 200, 255);
        send_a(128, 0, 255, 255, 0);
        send_a(128, 255, 0, 0, 255);
        send_a(255, 10, 20, 240, 250);
        drain(1'b0);

        a_rand_rdy = 1'b1;
        for (int k = 0; k < 64; k++)
            send_a($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                   $urandom_range(0, 255), $urandom_range(0, 255));
        drain(1'b0);
        a_rand_rdy = 1'b0;

        // Reset with three beats in flight: none may ever come out.
        send_a(10, 1, 2, 3, 4);
        send_a(20, 5, 6, 7, 8);
        send_a(30, 9, 10, 11, 12);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        a_exp.delete();
        check("mid_rst_out_valid", a_out_valid, 0);
        check("mid_rst_out_pix", a_out_pix, 0);
        check("mid_rst_in_ready", a_in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            if (a_out_valid) seen++;
        end
        check("mid_rst_no_emit", seen, 0);

        b_rand_rdy = 1'b1;
        for (int t = 0; t < 4096; t++) send_b(t, 1023, 0, 1023, 0);
        drain(1'b1);
        b_rand_rdy = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
